// File: rtl/digit_overlay_pkg.sv
// Shared constants and types for the on-screen BCD digit overlay.
package digit_overlay_pkg;

  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 16;
  localparam int COLOR_W  = 6;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [3:0]         bcd_t;

  localparam color_t COLOR_WHITE = 6'b111111;
  localparam color_t COLOR_BLACK = 6'b000000;

endpackage

// File: rtl/digit_overlay_glyph_addr_gen.sv
// Raster position -> digit box membership, digit index and glyph column/row.
// Purely combinational; the caller registers the results.
module glyph_addr_gen
  import digit_overlay_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int ORIGIN_X   = 16,
  parameter int ORIGIN_Y   = 16,
  parameter int SCALE_LOG2 = 1
) (
  input  logic [9:0] hcount_i,
  input  logic [9:0] vcount_i,
  input  logic       video_on_i,
  output logic       in_box_o,
  output logic [9:0] didx_o,
  output logic [4:0] col_o,
  output logic [4:0] row_o
);

  localparam logic [9:0] X_LO = 10'(ORIGIN_X);
  localparam logic [9:0] X_HI = 10'(ORIGIN_X + NUM_DIGITS * (GLYPH_W << SCALE_LOG2));
  localparam logic [9:0] Y_LO = 10'(ORIGIN_Y);
  localparam logic [9:0] Y_HI = 10'(ORIGIN_Y + (GLYPH_H << SCALE_LOG2));
  localparam int         DIDX_SHIFT = $clog2(GLYPH_W) + SCALE_LOG2;

  logic [9:0] x_off;
  logic [9:0] y_off;

  // Coordinates left of / above the origin wrap to large offsets and fall out of the box.
  always_comb begin
    x_off    = hcount_i - X_LO;
    y_off    = vcount_i - Y_LO;
    in_box_o = video_on_i
               && (hcount_i >= X_LO) && (hcount_i < X_HI)
               && (vcount_i >= Y_LO) && (vcount_i < Y_HI)
               && (hcount_i < 10'(H_ACTIVE));
    didx_o   = x_off >> DIDX_SHIFT;
    col_o    = 5'((x_off >> SCALE_LOG2) & 10'd7);
    row_o    = 5'((y_off >> SCALE_LOG2) & 10'd15);
  end

endmodule

// File: rtl/digit_overlay.sv
// Renders a latched BCD reading as glyphs over the background video stream.
// Two pipeline stages: address/blank decode, then colour compositing.
module digit_overlay
  import digit_overlay_pkg::*;
#(
  parameter int NUM_DIGITS    = 3,
  parameter int ORIGIN_X      = 16,
  parameter int ORIGIN_Y      = 16,
  parameter int SCALE_LOG2    = 1,
  parameter int BLANK_LEADING = 1,
  parameter int TRANSPARENT   = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [9:0]              hcount_i,
  input  logic [9:0]              vcount_i,
  input  logic                    video_on_i,
  input  logic                    hsync_in_i,
  input  logic                    vsync_in_i,
  input  color_t                  bg_pixel_i,
  input  logic [4*NUM_DIGITS-1:0] value_bcd_i,
  input  logic                    value_valid_i,
  output bcd_t                    glyph_digit_o,
  output logic [4:0]              glyph_col_o,
  output logic [4:0]              glyph_row_o,
  input  color_t                  glyph_data_i,
  output color_t                  pixel_out_o,
  output logic                    hsync_out_o,
  output logic                    vsync_out_o,
  output logic                    video_on_out_o
);

  localparam int VW = 4 * NUM_DIGITS;

  logic [VW-1:0] pending_q, pending_d, shadow_q, shadow_d;
  logic          pend_flag_q, pend_flag_d;
  bcd_t          digit_q, digit_d;
  logic [4:0]    col_q, row_q;
  logic          blank_q, blank_d;
  color_t        bg1_q;
  logic          hs1_q, vs1_q, von1_q;
  color_t        pixel_q, pixel_d;
  logic          hs2_q, vs2_q, von2_q;

  logic       in_box;
  logic [9:0] didx;
  logic [4:0] col, row;
  logic       latch;
  logic       lead_zero, zeros_so_far;

  glyph_addr_gen #(
    .NUM_DIGITS(NUM_DIGITS),
    .ORIGIN_X  (ORIGIN_X),
    .ORIGIN_Y  (ORIGIN_Y),
    .SCALE_LOG2(SCALE_LOG2)
  ) u_addr (
    .hcount_i  (hcount_i),
    .vcount_i  (vcount_i),
    .video_on_i(video_on_i),
    .in_box_o  (in_box),
    .didx_o    (didx),
    .col_o     (col),
    .row_o     (row)
  );

  // Shadow only moves on the first blanking line, so a frame never tears.
  always_comb begin
    latch       = (hcount_i == 10'd0) && (vcount_i == 10'(V_ACTIVE));
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    if (latch && pend_flag_q) begin
      shadow_d    = pending_q;
      pend_flag_d = 1'b0;
    end
    if (value_valid_i) begin
      pending_d   = value_bcd_i;
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    digit_d      = '0;
    lead_zero    = 1'b0;
    zeros_so_far = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zeros_so_far = zeros_so_far && (shadow_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      if (didx == 10'(i)) begin
        digit_d   = shadow_q[4*(NUM_DIGITS-1-i) +: 4];
        lead_zero = zeros_so_far && (i < NUM_DIGITS - 1);
      end
    end
    blank_d = !in_box || (digit_d > 4'd9) || ((BLANK_LEADING != 0) && lead_zero);
  end

  always_comb begin
    pixel_d = COLOR_BLACK;
    if (von1_q) begin
      if (blank_q || ((TRANSPARENT != 0) && (glyph_data_i == COLOR_WHITE)))
        pixel_d = bg1_q;
      else
        pixel_d = glyph_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      shadow_q    <= '0;
      digit_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      blank_q     <= 1'b0;
      bg1_q       <= '0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      von1_q      <= 1'b0;
      pixel_q     <= '0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      von2_q      <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      shadow_q    <= shadow_d;
      digit_q     <= digit_d;
      col_q       <= col;
      row_q       <= row;
      blank_q     <= blank_d;
      bg1_q       <= bg_pixel_i;
      hs1_q       <= hsync_in_i;
      vs1_q       <= vsync_in_i;
      von1_q      <= video_on_i;
      pixel_q     <= pixel_d;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      von2_q      <= von1_q;
    end
  end

  assign glyph_digit_o  = digit_q;
  assign glyph_col_o    = col_q;
  assign glyph_row_o    = row_q;
  assign pixel_out_o    = pixel_q;
  assign hsync_out_o    = hs2_q;
  assign vsync_out_o    = vs2_q;
  assign video_on_out_o = von2_q;

endmodule

// File: tb/tb_digit_overlay.sv
// Bench for digit_overlay: scoreboarded raster sweeps plus a table of hand-computed pixels.
module tb_digit_overlay;
  import digit_overlay_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic        video_on, hsync_in, vsync_in;
  logic [5:0]  bg_pixel;
  logic [11:0] value_bcd;
  logic        value_valid;
  logic [3:0]  glyph_digit;
  logic [4:0]  glyph_col, glyph_row;
  logic [5:0]  glyph_data;
  logic [5:0]  pixel_out;
  logic        hsync_out, vsync_out, video_on_out;

  always #5 clk = ~clk;

  digit_overlay dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .hcount_i      (hcount),
    .vcount_i      (vcount),
    .video_on_i    (video_on),
    .hsync_in_i    (hsync_in),
    .vsync_in_i    (vsync_in),
    .bg_pixel_i    (bg_pixel),
    .value_bcd_i   (value_bcd),
    .value_valid_i (value_valid),
    .glyph_digit_o (glyph_digit),
    .glyph_col_o   (glyph_col),
    .glyph_row_o   (glyph_row),
    .glyph_data_i  (glyph_data),
    .pixel_out_o   (pixel_out),
    .hsync_out_o   (hsync_out),
    .vsync_out_o   (vsync_out),
    .video_on_out_o(video_on_out)
  );

  // Stand-in glyph ROM: arbitrary but address-sensitive, with a black and a white point.
  function automatic logic [5:0] rom(input logic [3:0] d, input logic [4:0] c, input logic [4:0] r);
    if (c == 5'd1 && r == 5'd7) return 6'd0;
    if (c == 5'd0 && r == 5'd0) return 6'h3F;
    return 6'(int'(d) * 5 + int'(c) * 8 + int'(r) * 3 + 1);
  endfunction

  assign glyph_data = rom(glyph_digit, glyph_col, glyph_row);

  typedef struct {
    int         hc, vc;
    logic [5:0] pix;
    logic       hs, vs, von;
  } exp_t;

  typedef struct {
    logic [9:0] hc, vc;
    logic       von;
    logic [5:0] bg;
    bit         chk;
    logic [3:0] dig;
    logic [4:0] col, row;
    logic [5:0] pix;
  } vec_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [11:0] m_shadow = '0, m_pend = '0;
  bit          m_flag = 0;

  // Reference for the default configuration: 3 digits at (16,16), 2x scale, box 48x32.
  function automatic logic [5:0] model_pix(input logic [9:0] hc, input logic [9:0] vc,
                                           input logic von, input logic [5:0] bg,
                                           input logic [11:0] sh);
    logic [9:0] xo, yo;
    logic       inb, blank, bl;
    int         di;
    logic [4:0] c, r;
    logic [3:0] nib;
    logic [5:0] d;
    xo  = hc - 10'd16;
    yo  = vc - 10'd16;
    inb = von && hc >= 16 && hc < 64 && vc >= 16 && vc < 48;
    di  = int'(xo >> 4);
    c   = 5'((xo >> 1) & 10'd7);
    r   = 5'((yo >> 1) & 10'd15);
    nib = (di < 3) ? sh[4*(2-di) +: 4] : 4'd0;
    bl  = (di == 0 && sh[11:8] == 4'd0) || (di == 1 && sh[11:4] == 8'd0);
    blank = !inb || nib > 4'd9 || bl;
    d = rom(nib, c, r);
    if (!von) return 6'd0;
    if (blank || d == 6'h3F) return bg;
    return d;
  endfunction

  task automatic step(input logic [9:0] hc, input logic [9:0] vc, input logic von,
                      input logic hs, input logic vs, input logic [5:0] bg,
                      input logic vv, input logic [11:0] vb, input logic rst,
                      input bit use_exp, input logic [5:0] xpix);
    exp_t e, x;
    hcount = hc; vcount = vc; video_on = von; hsync_in = hs; vsync_in = vs;
    bg_pixel = bg; value_valid = vv; value_bcd = vb; reset = rst;
    e.hc = int'(hc); e.vc = int'(vc);
    if (rst) begin
      e.pix = '0; e.hs = 1'b0; e.vs = 1'b0; e.von = 1'b0;
      if (q.size() > 0) begin
        q[q.size()-1].pix = '0; q[q.size()-1].hs = 1'b0;
        q[q.size()-1].vs  = 1'b0; q[q.size()-1].von = 1'b0;
      end
      m_shadow = '0; m_pend = '0; m_flag = 0;
    end else begin
      e.pix = use_exp ? xpix : model_pix(hc, vc, von, bg, m_shadow);
      e.hs = hs; e.vs = vs; e.von = von;
      if (hc == 10'd0 && vc == 10'd480 && m_flag) begin
        m_shadow = m_pend; m_flag = 0;
      end
      if (vv) begin
        m_pend = vb; m_flag = 1;
      end
    end
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() >= 2) begin
      x = q.pop_front();
      total++;
      if ({pixel_out, hsync_out, vsync_out, video_on_out} !== {x.pix, x.hs, x.vs, x.von}) begin
        bad++;
        $display("FAIL out h=%0d v=%0d: got pix=%b hs=%b vs=%b von=%b, want pix=%b hs=%b vs=%b von=%b",
                 x.hc, x.vc, pixel_out, hsync_out, vsync_out, video_on_out,
                 x.pix, x.hs, x.vs, x.von);
      end
    end
  endtask

  task automatic frame(input bit strobe, input int sh, input int sv, input logic [11:0] vb,
                       input int rst_v);
    logic [5:0] bg;
    for (int v = 0; v < 50; v++) begin
      for (int h = 0; h < 80; h++) begin
        bg = (v < 25) ? 6'b010101 : 6'(h + 2 * v);
        step(10'(h), 10'(v), (h < 76) && (v != 20), h >= 70, v < 2, bg,
             strobe && h == sh && v == sv, vb, (v == rst_v) && (h == 30 || h == 31), 0, '0);
      end
    end
  endtask

  task automatic latch_pt(input logic vv, input logic [11:0] vb);
    step(10'd0, 10'd480, 1'b0, 1'b0, 1'b1, 6'd9, vv, vb, 1'b0, 0, '0);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{10'd35, 10'd30, 1'b1, 6'd21, 1'b1, 4'd7, 5'd1, 5'd7,  6'd0};
    tbl[1]  = '{10'd18, 10'd18, 1'b1, 6'd21, 1'b1, 4'd1, 5'd1, 5'd1,  6'd17};
    tbl[2]  = '{10'd16, 10'd16, 1'b1, 6'd21, 1'b1, 4'd1, 5'd0, 5'd0,  6'd21};
    tbl[3]  = '{10'd63, 10'd47, 1'b1, 6'd21, 1'b1, 4'd9, 5'd7, 5'd15, 6'd19};
    tbl[4]  = '{10'd48, 10'd20, 1'b1, 6'd21, 1'b1, 4'd9, 5'd0, 5'd2,  6'd52};
    tbl[5]  = '{10'd47, 10'd30, 1'b1, 6'd21, 1'b1, 4'd7, 5'd7, 5'd7,  6'd49};
    tbl[6]  = '{10'd15, 10'd30, 1'b1, 6'd21, 1'b0, 4'd0, 5'd0, 5'd0,  6'd21};
    tbl[7]  = '{10'd64, 10'd30, 1'b1, 6'd21, 1'b0, 4'd0, 5'd0, 5'd0,  6'd21};
    tbl[8]  = '{10'd16, 10'd48, 1'b1, 6'd21, 1'b0, 4'd0, 5'd0, 5'd0,  6'd21};
    tbl[9]  = '{10'd16, 10'd15, 1'b1, 6'd21, 1'b0, 4'd0, 5'd0, 5'd0,  6'd21};
    tbl[10] = '{10'd35, 10'd30, 1'b0, 6'd21, 1'b1, 4'd7, 5'd1, 5'd7,  6'd0};

    for (int i = 0; i < 4; i++) step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 6'd21, 1'b0, '0, 1'b1, 0, '0);

    frame(1, 40, 30, 12'h123, -1);   // blank raster, mid-frame strobe must not show
    latch_pt(1'b0, '0);
    frame(1, 10, 5, 12'h0A5, -1);    // shows 123
    latch_pt(1'b1, 12'h456);         // coincident strobe: 0A5 latched, 456 stays pending
    frame(0, 0, 0, '0, -1);          // shows 0A5 with blanked leading/invalid digits
    latch_pt(1'b0, '0);
    frame(0, 0, 0, '0, -1);          // shows 456

    step(10'd5, 10'd200, 1'b1, 1'b0, 1'b0, 6'd21, 1'b1, 12'h179, 1'b0, 0, '0);
    latch_pt(1'b0, '0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].hc, tbl[i].vc, tbl[i].von, 1'b0, 1'b0, tbl[i].bg, 1'b0, '0, 1'b0, 1, tbl[i].pix);
      if (tbl[i].chk) begin
        total++;
        if ({glyph_digit, glyph_col, glyph_row} !== {tbl[i].dig, tbl[i].col, tbl[i].row}) begin
          bad++;
          $display("FAIL glyph_addr vec %0d: got digit=%0d col=%0d row=%0d, want digit=%0d col=%0d row=%0d",
                   i, glyph_digit, glyph_col, glyph_row, tbl[i].dig, tbl[i].col, tbl[i].row);
        end
      end
    end

    frame(1, 50, 40, 12'h808, 25);   // reset mid-box: shadow and pending drop to 0
    latch_pt(1'b0, '0);
    frame(0, 0, 0, '0, -1);

    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, '0, 1'b0, 0, '0);
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, '0, 1'b0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_overlay.md
Name: digit_overlay

Overview:
- Reader side of the glyph-ROM interface. Scans the VGA raster, converts the current pixel into a (digit, glyph column, glyph row) lookup, and drives the per-digit glyph ROMs through an external mux.
- Registers the returned 6-bit colour and composites it over the background video stream.
- Renders the latched height reading as NUM_DIGITS BCD digits at a fixed screen position, with sync signals delayed to match.

Parameters:
- NUM_DIGITS, 3, number of BCD digits rendered left to right, most significant digit first.
- ORIGIN_X, 16, screen x of the digit box's left edge.
- ORIGIN_Y, 16, screen y of the digit box's top edge.
- SCALE_LOG2, 1, on-screen pixels per glyph pixel is 2^SCALE_LOG2 (legal values 0..2).
- BLANK_LEADING, 1, when 1, leading zero digits (all except the last) render as background.
- TRANSPARENT, 1, when 1, glyph white (6'b111111) shows bg_pixel instead.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hcount  in  10  current raster x
- vcount  in  10  current raster y
- video_on  in  1  active-video flag
- hsync_in  in  1  raw hsync
- vsync_in  in  1  raw vsync
- bg_pixel  in  6  background colour at (hcount, vcount)
- value_bcd  in  4*NUM_DIGITS  new reading, digit 0 in the MS nibble
- value_valid  in  1  single-cycle strobe: value_bcd is valid
- glyph_digit  out  4  digit selector to the ROM mux
- glyph_col  out  5  glyph column, 0..7
- glyph_row  out  5  glyph row, 0..15
- glyph_data  in  6  combinational ROM mux return for glyph_digit/col/row
- pixel_out  out  6  composited colour
- hsync_out  out  1  hsync delayed 2 cycles
- vsync_out  out  1  vsync delayed 2 cycles
- video_on_out  out  1  video_on delayed 2 cycles

Behaviour:
- **Reset.** Every register clears to 0: pixel_out, syncs, video_on_out, glyph_* outputs, the pending value/flag and the shadow value.
  - The display therefore shows "0" (or "000" when BLANK_LEADING=0) until the first latch.
- **Value capture.** value_valid=1 loads value_bcd into pending and sets pend_flag. A later strobe overwrites pending.
- **Frame latch.** The latch point is the cycle where hcount==0 and vcount==V_ACTIVE (480), i.e. the first blanking line.
  - If pend_flag is set at the latch point: shadow <= pending and pend_flag clears.
  - If value_valid coincides with the latch point: shadow takes the old pending, pending takes the new value, and pend_flag stays 1.
  - Shadow never changes during active video, so no tearing.
- **Stage 1 (registered, from inputs).**
  - x_off = hcount-ORIGIN_X and y_off = vcount-ORIGIN_Y, both 10-bit unsigned.
  - in_box = video_on && hcount>=ORIGIN_X && hcount<ORIGIN_X+NUM_DIGITS*(8<<SCALE_LOG2) && vcount>=ORIGIN_Y && vcount<ORIGIN_Y+(16<<SCALE_LOG2).
  - didx = x_off>>(3+SCALE_LOG2).
  - glyph_col = (x_off>>SCALE_LOG2)&7.
  - glyph_row = (y_off>>SCALE_LOG2)&15.
  - glyph_digit = shadow nibble didx.
  - blank = !in_box, OR the nibble is >9, OR (BLANK_LEADING and nibble==0 and didx<NUM_DIGITS-1 and every more-significant nibble is 0).
  - Outside the box, glyph_* are still driven but unused. bg_pixel, syncs and video_on are delayed into stage 1.
- **Stage 2 (registered).**
  - pixel_out = 0 when the stage-1 video_on is 0.
  - Otherwise pixel_out = bg_pixel when blank, or when TRANSPARENT and glyph_data==6'b111111.
  - Otherwise pixel_out = glyph_data.
- **Latency.** Exactly 2 clk from hcount/vcount/bg_pixel/syncs to pixel_out/syncs_out, for every pixel.
- **Mid-frame reset.** Outputs are 0 while reset is high and for 2 cycles after, then track the input with the fixed 2-cycle latency. Shadow reads 0 until the next latch.
- **Clipping.** hcount/vcount wrapping below ORIGIN makes x_off large, so in_box=0. No special case is needed.

Decomposition:
- Package digit_overlay_pkg holds:
  - GLYPH_W=8, GLYPH_H=16, COLOR_W=6, H_ACTIVE=640, V_ACTIVE=480.
  - COLOR_WHITE=6'b111111, COLOR_BLACK=6'b000000.
  - typedef color_t (logic [5:0]) and typedef bcd_t (logic [3:0]).
- Sub-module glyph_addr_gen: purely combinational coordinate math (in_box, didx, col, row). Stage 1 registers its outputs.
- The glyph ROM mux (digit -> per-digit ROM instance) stays outside this block.

Test Plan:
- **Reset and blank raster.** reset for 4 cycles, then raster with bg_pixel=6'b010101 and no value -> 2 cycles after release, pixel_out=6'b010101 everywhere except the last digit cell, which shows glyph 0; video_on=0 gives pixel_out=0.
- **Coordinate mapping.** SCALE_LOG2=1, shadow=BCD 0x179, hcount=35, vcount=30 -> glyph_digit=7, glyph_col=1, glyph_row=7 one cycle later. With glyph_data=6'b000000 returned, pixel_out=6'b000000 two cycles after the input.
- **Box edges.** hcount=15 and hcount=64 (box ends at 63), vcount=16..47 -> pixel_out=bg_pixel at 15 and 64. At hcount=16 the glyph path is used.
- **Frame latch timing.** Strobe value_valid with 0x123 mid-frame at vcount=200 -> output is unchanged for the rest of the frame. The next frame shows 1,2,3.
- **Coincident strobe.** value_valid with 0x456 exactly at hcount=0, vcount=480 while pending=0x123 -> shadow=0x123 and pend_flag stays 1. 0x456 appears one frame later.
- **Blanking rules.** Shadow 0x0A5 with BLANK_LEADING=1 -> digit0 (leading 0) and digit1 (invalid A) render bg_pixel; digit2 renders glyph 5 pixels.
